// File: rtl/nibble_packer_pkg.sv
// Shared types, state encoding and the nibble-pair packing function for nibble_packer.
package nibble_packer_pkg;

    localparam int NIB_W  = 4;
    localparam int BYTE_W = 8;

    typedef logic [1:0] state_t;

    localparam state_t IDLE      = 2'd0;
    localparam state_t HALF      = 2'd1;
    localparam state_t FULL      = 2'd2;
    localparam state_t FULL_HALF = 2'd3;

    // The first-arriving nibble lands in the high half unless lsb_first is set.
    function automatic logic [BYTE_W-1:0] pack(
        input logic [NIB_W-1:0] first,
        input logic [NIB_W-1:0] second,
        input logic             lsb_first
    );
        return lsb_first ? {second, first} : {first, second};
    endfunction

endpackage

// File: rtl/nibble_packer_wrap_counter.sv
// Free-running wrap-around event counter with synchronous active-high reset.
module wrap_counter #(
    parameter int W = 8
) (
    input  logic         clk,
    input  logic         rst,
    input  logic         inc,
    output logic [W-1:0] count
);

    logic [W-1:0] count_q;
    logic [W-1:0] count_d;

    always_comb begin
        count_d = count_q;
        if (inc) begin
            count_d = count_q + 1'b1;
        end
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            count_q <= '0;
        end else begin
            count_q <= count_d;
        end
    end

    assign count = count_q;

endmodule

// File: rtl/nibble_packer.sv
// Packs pairs of 4-bit nibbles into bytes with one byte of output buffering plus
// one pending nibble. Optional zero-padded flush of a lone nibble: PACKER_FLUSH_EN.
module nibble_packer
    import nibble_packer_pkg::*;
#(
    parameter int LSB_FIRST = 0,
    parameter int CNT_W     = 8
) (
    input  logic             clk,
    input  logic             rst,
    input  logic [NIB_W-1:0] in_data,
    input  logic             in_valid,
    output logic             in_ready,
    output logic [BYTE_W-1:0] out_data,
    output logic             out_valid,
    input  logic             out_ready,
`ifdef PACKER_FLUSH_EN
    input  logic             flush,
`endif
    output logic [CNT_W-1:0] byte_count
);

    localparam logic LSB_SEL = (LSB_FIRST != 0);

    state_t            state_q;
    state_t            state_d;
    logic [NIB_W-1:0]  hold_q;
    logic [NIB_W-1:0]  hold_d;
    logic [BYTE_W-1:0] data_q;
    logic [BYTE_W-1:0] data_d;

    logic in_fire;
    logic out_fire;
    logic flush_req;

`ifdef PACKER_FLUSH_EN
    assign flush_req = flush;
`else
    assign flush_req = 1'b0;
`endif

    assign in_fire  = in_valid & in_ready;
    assign out_fire = out_valid & out_ready;

    always_ff @(posedge clk) begin
        if (rst) begin
            state_q <= IDLE;
            hold_q  <= '0;
            data_q  <= '0;
        end else begin
            state_q <= state_d;
            hold_q  <= hold_d;
            data_q  <= data_d;
        end
    end

    always_comb begin
        state_d = state_q;
        hold_d  = hold_q;
        data_d  = data_q;
        case (state_q)
            IDLE: begin
                if (in_fire) begin
                    state_d = HALF;
                    hold_d  = in_data;
                end
            end
            HALF: begin
                // A real nibble takes priority over a flush in the same cycle.
                if (in_fire) begin
                    state_d = FULL;
                    data_d  = pack(hold_q, in_data, LSB_SEL);
                end else if (flush_req) begin
                    state_d = FULL;
                    data_d  = pack(hold_q, {NIB_W{1'b0}}, LSB_SEL);
                end
            end
            FULL: begin
                if (out_fire && in_fire) begin
                    state_d = HALF;
                    hold_d  = in_data;
                end else if (out_fire) begin
                    state_d = IDLE;
                end else if (in_fire) begin
                    state_d = FULL_HALF;
                    hold_d  = in_data;
                end
            end
            FULL_HALF: begin
                if (out_fire) begin
                    state_d = HALF;
                end
            end
            default: begin
                state_d = IDLE;
            end
        endcase
    end

    // Pure state decode: in_ready never depends combinationally on out_ready.
    always_comb begin
        in_ready  = (state_q != FULL_HALF);
        out_valid = (state_q == FULL) || (state_q == FULL_HALF);
        out_data  = data_q;
    end

    wrap_counter #(
        .W(CNT_W)
    ) u_byte_count (
        .clk  (clk),
        .rst  (rst),
        .inc  (out_fire),
        .count(byte_count)
    );

endmodule

// File: tb/tb_nibble_packer.sv
// Directed self-checking bench for nibble_packer (MSB-first and LSB-first instances).
module tb_nibble_packer;

    logic       clk = 1'b0;
    logic       rst;
    logic [3:0] in_data;
    logic       in_valid;
    logic       out_ready;
    logic       flush;

    logic       in_ready,  in_ready_l;
    logic [7:0] out_data,  out_data_l;
    logic       out_valid, out_valid_l;
    logic [7:0] byte_count, byte_count_l;

    int checks = 0;
    int fails  = 0;

    always #5 clk = ~clk;

    nibble_packer #(.LSB_FIRST(0), .CNT_W(8)) dut (
        .clk(clk), .rst(rst), .in_data(in_data), .in_valid(in_valid), .in_ready(in_ready),
        .out_data(out_data), .out_valid(out_valid), .out_ready(out_ready),
`ifdef PACKER_FLUSH_EN
        .flush(flush),
`endif
        .byte_count(byte_count)
    );

    nibble_packer #(.LSB_FIRST(1), .CNT_W(8)) dut_lsb (
        .clk(clk), .rst(rst), .in_data(in_data), .in_valid(in_valid), .in_ready(in_ready_l),
        .out_data(out_data_l), .out_valid(out_valid_l), .out_ready(out_ready),
`ifdef PACKER_FLUSH_EN
        .flush(flush),
`endif
        .byte_count(byte_count_l)
    );

    function automatic logic [3:0] nib(input int k);
        logic [31:0] v;
        v = k * 3 + 1;
        return v[3:0];
    endfunction

    task automatic do_reset();
        @(negedge clk);
        rst = 1'b1; in_valid = 1'b0; out_ready = 1'b0; flush = 1'b0; in_data = 4'h0;
        @(negedge clk);
        @(negedge clk);
        rst = 1'b0;
    endtask

    task automatic test_reset();
        do_reset();
        checks++; if (out_valid !== 1'b0) begin fails++; $display("FAIL reset_out_valid: got %b expected 0", out_valid); end
        checks++; if (out_data !== 8'h00) begin fails++; $display("FAIL reset_out_data: got %h expected 00", out_data); end
        checks++; if (byte_count !== 8'd0) begin fails++; $display("FAIL reset_count: got %0d expected 0", byte_count); end
        checks++; if (in_ready !== 1'b1) begin fails++; $display("FAIL reset_in_ready: got %b expected 1", in_ready); end
    endtask

    task automatic test_basic();
        in_valid = 1'b1; in_data = 4'hA; out_ready = 1'b1;
        @(negedge clk);
        in_data = 4'h5;
        @(negedge clk);
        in_valid = 1'b0; in_data = 4'hE;
        checks++; if (out_valid !== 1'b1) begin fails++; $display("FAIL basic_valid: got %b expected 1", out_valid); end
        checks++; if (out_data !== 8'hA5) begin fails++; $display("FAIL basic_msb_data: got %h expected a5", out_data); end
        checks++; if (out_data_l !== 8'h5A) begin fails++; $display("FAIL basic_lsb_data: got %h expected 5a", out_data_l); end
        $display("byte delivered: msb-first %h, lsb-first %h", out_data, out_data_l);
        @(negedge clk);
        checks++; if (out_valid !== 1'b0) begin fails++; $display("FAIL basic_valid_drop: got %b expected 0", out_valid); end
        checks++; if (byte_count !== 8'd1) begin fails++; $display("FAIL basic_count: got %0d expected 1", byte_count); end
        checks++; if (byte_count_l !== 8'd1) begin fails++; $display("FAIL basic_lsb_count: got %0d expected 1", byte_count_l); end
    endtask

    task automatic test_stall();
        out_ready = 1'b0; in_valid = 1'b1; in_data = 4'h1;
        @(negedge clk);
        in_data = 4'h2;
        @(negedge clk);
        checks++; if (out_data !== 8'h12) begin fails++; $display("FAIL stall_full_data: got %h expected 12", out_data); end
        checks++; if (in_ready !== 1'b1) begin fails++; $display("FAIL stall_full_ready: got %b expected 1", in_ready); end
        in_data = 4'h3;
        @(negedge clk);
        for (int i = 0; i < 10; i++) begin
            checks++; if (out_data !== 8'h12 || out_valid !== 1'b1) begin fails++; $display("FAIL stall_hold[%0d]: got %h/%b expected 12/1", i, out_data, out_valid); end
            checks++; if (in_ready !== 1'b0) begin fails++; $display("FAIL stall_in_ready[%0d]: got %b expected 0", i, in_ready); end
            in_data = 4'(i + 7);
            @(negedge clk);
        end
        out_ready = 1'b1; in_valid = 1'b0;
        @(negedge clk);
        $display("byte delivered after stall: 12, count %0d", byte_count);
        checks++; if (out_valid !== 1'b0) begin fails++; $display("FAIL stall_release_valid: got %b expected 0", out_valid); end
        checks++; if (in_ready !== 1'b1) begin fails++; $display("FAIL stall_release_ready: got %b expected 1", in_ready); end
        checks++; if (byte_count !== 8'd2) begin fails++; $display("FAIL stall_count: got %0d expected 2", byte_count); end
        in_valid = 1'b1; in_data = 4'h4;
        @(negedge clk);
        in_valid = 1'b0;
        checks++; if (out_data !== 8'h34 || out_valid !== 1'b1) begin fails++; $display("FAIL stall_pending_pair: got %h/%b expected 34/1", out_data, out_valid); end
        @(negedge clk);
        checks++; if (byte_count !== 8'd3) begin fails++; $display("FAIL stall_count2: got %0d expected 3", byte_count); end
    endtask

    task automatic test_reset_mid();
        out_ready = 1'b1; in_valid = 1'b1; in_data = 4'hF;
        @(negedge clk);
        in_valid = 1'b0; rst = 1'b1;
        @(negedge clk);
        rst = 1'b0;
        checks++; if (byte_count !== 8'd0) begin fails++; $display("FAIL midreset_count: got %0d expected 0", byte_count); end
        in_valid = 1'b1; in_data = 4'h1;
        @(negedge clk);
        in_data = 4'h2;
        @(negedge clk);
        in_valid = 1'b0;
        checks++; if (out_data !== 8'h12 || out_valid !== 1'b1) begin fails++; $display("FAIL midreset_data: got %h/%b expected 12/1", out_data, out_valid); end
        @(negedge clk);
    endtask

    task automatic test_back_to_back();
        logic [7:0] exp;
        do_reset();
        out_ready = 1'b1; in_valid = 1'b1;
        for (int i = 0; i < 512; i++) begin
            checks++; if (in_ready !== 1'b1) begin fails++; $display("FAIL stream_ready[%0d]: got %b expected 1", i, in_ready); end
            if (i >= 2 && (i % 2) == 0) begin
                exp = {nib(i - 2), nib(i - 1)};
                checks++; if (out_valid !== 1'b1 || out_data !== exp) begin fails++; $display("FAIL stream_byte[%0d]: got %h/%b expected %h/1", i, out_data, out_valid, exp); end
            end else if (i >= 1) begin
                checks++; if (out_valid !== 1'b0) begin fails++; $display("FAIL stream_gap[%0d]: got %b expected 0", i, out_valid); end
            end
            in_data = nib(i);
            @(negedge clk);
        end
        in_valid = 1'b0;
        exp = {nib(510), nib(511)};
        checks++; if (out_valid !== 1'b1 || out_data !== exp) begin fails++; $display("FAIL stream_last: got %h/%b expected %h/1", out_data, out_valid, exp); end
        @(negedge clk);
        $display("stream of 512 nibbles done, count %0d", byte_count);
        checks++; if (byte_count !== 8'd0) begin fails++; $display("FAIL stream_wrap: got %0d expected 0", byte_count); end
        checks++; if (out_valid !== 1'b0) begin fails++; $display("FAIL stream_idle: got %b expected 0", out_valid); end
    endtask

`ifdef PACKER_FLUSH_EN
    task automatic test_flush();
        do_reset();
        in_valid = 1'b1; in_data = 4'hC;
        @(negedge clk);
        in_valid = 1'b0; flush = 1'b1;
        @(negedge clk);
        flush = 1'b0;
        checks++; if (out_data !== 8'hC0 || out_valid !== 1'b1) begin fails++; $display("FAIL flush_data: got %h/%b expected c0/1", out_data, out_valid); end
        out_ready = 1'b1;
        @(negedge clk);
        out_ready = 1'b0;
        checks++; if (byte_count !== 8'd1) begin fails++; $display("FAIL flush_count: got %0d expected 1", byte_count); end
        flush = 1'b1;
        @(negedge clk);
        flush = 1'b0; out_ready = 1'b1;
        @(negedge clk);
        checks++; if (out_valid !== 1'b0) begin fails++; $display("FAIL flush_idle_valid: got %b expected 0", out_valid); end
        checks++; if (byte_count !== 8'd1) begin fails++; $display("FAIL flush_idle_count: got %0d expected 1", byte_count); end
    endtask
`endif

    initial begin
        rst = 1'b1; in_valid = 1'b0; out_ready = 1'b0; flush = 1'b0; in_data = 4'h0;
        test_reset();
        test_basic();
        test_stall();
        test_reset_mid();
        test_back_to_back();
`ifdef PACKER_FLUSH_EN
        test_flush();
`endif
        $display("End of test - %0d assertions evaluated, %0d failures", checks, fails);
        $finish;
    end

endmodule

// File: doc/nibble_packer.md
Name: nibble_packer

Overview:
- Sits upstream of the team's vector slicing/concatenation stages.
- Accepts a stream of 4-bit nibbles over a valid/ready handshake and concatenates each consecutive pair into one 8-bit byte.
- Presents each byte on a valid/ready output and keeps a running count of bytes delivered.
- Has one byte of output buffering plus one pending nibble, so the input can keep streaming while the consumer stalls.

Parameters:
- LSB_FIRST, 0: 0 packs the first nibble into out_data[7:4] ({first, second}); 1 packs it into out_data[3:0] ({second, first}).
- CNT_W, 8: width of byte_count.

Ports:
- clk  input  1  rising-edge clock
- rst  input  1  synchronous, active-high reset
- in_data  input  4  nibble payload
- in_valid  input  1  in_data is valid
- in_ready  output  1  packer accepts a nibble this cycle
- out_data  output  8  packed byte
- out_valid  output  1  out_data is valid
- out_ready  input  1  consumer accepts the byte
- byte_count  output  CNT_W  number of bytes delivered (out fires), modulo 2^CNT_W
- flush  input  1  present only with PACKER_FLUSH_EN

Behaviour:
- Interface: one clock (clk); reset is synchronous and active-high (rst). All state updates on rising clk.
- Fire definitions: in_fire = in_valid & in_ready; out_fire = out_valid & out_ready.
- Reset values (rst high at an edge):
  - state = IDLE; out_valid = 0; out_data = 8'h00; byte_count = 0.
  - Internal hi nibble register = 4'h0; in_ready = 1 in the following cycle.
  - Reset overrides any fire in the same cycle; a partially packed pair is discarded.
- States: IDLE (nothing held), HALF (first nibble held), FULL (byte held, out_valid=1), FULL_HALF (byte held plus next first nibble held).
- Output decoding:
  - in_ready = (state != FULL_HALF), a pure state decode with no combinational path from out_ready.
  - out_valid = state is FULL or FULL_HALF.
- Transitions:
  - IDLE: in_fire -> HALF; hold <= in_data.
  - HALF: in_fire -> FULL; out_data <= packed(hold, in_data).
  - FULL: out_fire & in_fire -> HALF (hold <= in_data); out_fire only -> IDLE; in_fire only -> FULL_HALF (hold <= in_data); otherwise stay.
  - FULL_HALF: out_fire -> HALF; otherwise stay. No input is accepted in this state.
- Timing:
  - Latency: out_valid rises on the edge that accepts the second nibble, so the byte is visible the cycle after that acceptance.
  - Sustained throughput is 1 nibble/cycle while out_ready stays high.
- Stability: out_data and out_valid must not change while out_valid=1 and out_ready=0.
- Counter: byte_count increments on every out_fire and wraps from 2^CNT_W-1 to 0 without saturating.
- in_data is ignored whenever in_fire=0.

Optional Feature:
- Macro: PACKER_FLUSH_EN.
- Defined:
  - Adds the flush input.
  - flush=1 in HALF with in_valid=0 -> FULL, with out_data = packed(hold, 4'h0), i.e. zero padding in the second-nibble position.
  - If in_fire and flush occur in the same cycle in HALF, the nibble wins and flush is ignored.
  - flush is ignored in IDLE, FULL and FULL_HALF.
- Undefined: no flush port; a lone nibble waits indefinitely for its partner.

Decomposition:
- Package nibble_packer_pkg holds:
  - State encoding localparams (IDLE=2'd0, HALF=2'd1, FULL=2'd2, FULL_HALF=2'd3).
  - NIB_W=4 and BYTE_W=8.
  - A pack function taking (first, second, lsb_first) and returning the byte.
- One sub-module is natural: wrap_counter (parameter W; inputs clk, rst, inc; output count) for byte_count.

Test Plan:
- Reset then nibbles 4'hA, 4'h5 with out_ready=1, LSB_FIRST=0 -> out_data=8'hA5 with out_valid for 1 cycle; byte_count=1.
- Same stimulus with LSB_FIRST=1 -> out_data=8'h5A.
- out_ready=0 with nibbles 1,2,3 driven continuously:
  - 1,2 give byte 8'h12 held in FULL; nibble 3 accepted into FULL_HALF; in_ready=0.
  - out_data stays 8'h12 for 10 cycles.
  - Raising out_ready delivers 8'h12 and moves the packer to HALF.
- 512 nibbles streamed with out_ready=1 every cycle -> 256 bytes, in_ready never drops, byte_count wraps to 0.
- rst asserted in HALF after nibble 4'hF -> next pair 4'h1, 4'h2 yields 8'h12, not 8'hF1.
- PACKER_FLUSH_EN: nibble 4'hC then flush=1 -> out_data=8'hC0; flush in IDLE -> no output and byte_count unchanged.
